// File: rtl/precision_game_pkg.sv
// Shared types and width helpers for the precision button-press game.
package precision_game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, OVER} state_t;

  function automatic int max1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/precision_game_core_sweep_ptr.sv
// Step timer and sweeping LED position; wraps or ping-pongs across WIDTH LEDs.
module sweep_ptr
  import precision_game_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BASE_DIV = 25_000_000,
  parameter int LEVELS   = 4,
  localparam int LW = max1_clog2(LEVELS),
  localparam int PW = max1_clog2(WIDTH),
  localparam int CW = max1_clog2(BASE_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LW-1:0]    level,
  input  logic             mode,
  input  logic             clear,
  input  logic             enable,
  output logic [PW-1:0]    ptr,
  output logic [WIDTH-1:0] leds
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          dir_down;
  logic          at_top;

  // Each level halves the step period.
  assign term   = CW'((BASE_DIV >> level) - 1);
  assign at_top = (ptr == PW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt      <= '0;
      ptr      <= '0;
      dir_down <= 1'b0;
    end else if (enable) begin
      if (cnt == term) begin
        cnt <= '0;
        if (!mode) begin
          ptr <= at_top ? '0 : ptr + 1'b1;
        end else if (dir_down) begin
          if (ptr == '0) begin
            ptr      <= PW'(1);
            dir_down <= 1'b0;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end else begin
          if (at_top) begin
            ptr      <= PW'(WIDTH - 2);
            dir_down <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign leds = WIDTH'(1) << ptr;

endmodule

// File: rtl/precision_game_core.sv
// Precision game engine: input synchronisers, game FSM, score/level/lives bookkeeping.
module precision_game_core
  import precision_game_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BASE_DIV       = 25_000_000,
  parameter int LEVELS         = 4,
  parameter int HITS_PER_LEVEL = 4,
  parameter int LIVES          = 3,
  parameter int SCORE_W        = 8,
  parameter int HOLD_CYC       = 50_000_000,
  localparam int LW  = max1_clog2(LEVELS),
  localparam int LIW = $clog2(LIVES + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               BTN,
  input  logic               MODE,
  input  logic [WIDTH-1:0]   SWITCHES,
  output logic [WIDTH-1:0]   LEDS,
  output logic [SCORE_W-1:0] SCORE,
  output logic [LW-1:0]      LEVEL,
  output logic [LIW-1:0]     LIVES_LEFT,
  output logic               HIT,
  output logic               MISS,
  output logic               GAME_OVER
);

  localparam int PW = max1_clog2(WIDTH);
  localparam int SW = $clog2(HITS_PER_LEVEL + 1);
  localparam int HW = max1_clog2(HOLD_CYC);

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  function automatic logic [LW-1:0] sat_inc_level(input logic [LW-1:0] l);
    return (l == LW'(LEVELS - 1)) ? l : l + 1'b1;
  endfunction

  logic start_p0, start_p1, start_p2;
  logic btn_p0, btn_p1, btn_p2;
  logic start_edge, btn_edge;

  // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      {start_p0, start_p1, start_p2} <= '0;
      {btn_p0, btn_p1, btn_p2}       <= '0;
    end else begin
      start_p0 <= START;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
      btn_p0   <= BTN;
      btn_p1   <= btn_p0;
      btn_p2   <= btn_p1;
    end
  end

  assign start_edge = start_p1 & ~start_p2;
  assign btn_edge   = btn_p1 & ~btn_p2;

  state_t          state;
  logic            mode_q;
  logic            hit_shown;
  logic [SW-1:0]   streak;
  logic [HW-1:0]   hold_cnt;
  logic [PW-1:0]   ptr;
  logic [WIDTH-1:0] sweep_leds;
  logic            on_target;

  sweep_ptr #(
    .WIDTH   (WIDTH),
    .BASE_DIV(BASE_DIV),
    .LEVELS  (LEVELS)
  ) u_sweep (
    .clk   (CLK),
    .rst   (RST),
    .level (LEVEL),
    .mode  (mode_q),
    .clear (state != RUN),
    .enable(state == RUN),
    .ptr   (ptr),
    .leds  (sweep_leds)
  );

  assign on_target = SWITCHES[ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      SCORE      <= '0;
      LEVEL      <= '0;
      LIVES_LEFT <= LIW'(LIVES);
      streak     <= '0;
      hold_cnt   <= '0;
      mode_q     <= 1'b0;
      hit_shown  <= 1'b0;
      HIT        <= 1'b0;
      MISS       <= 1'b0;
    end else begin
      HIT  <= 1'b0;
      MISS <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_edge) begin
            SCORE      <= '0;
            LEVEL      <= '0;
            LIVES_LEFT <= LIW'(LIVES);
            streak     <= '0;
            mode_q     <= MODE;
            state      <= RUN;
          end
        end
        RUN: begin
          if (btn_edge) begin
            hold_cnt  <= '0;
            hit_shown <= on_target;
            state     <= HOLD;
            if (on_target) begin
              HIT   <= 1'b1;
              SCORE <= sat_inc_score(SCORE);
              if (streak == SW'(HITS_PER_LEVEL - 1)) begin
                streak <= '0;
                LEVEL  <= sat_inc_level(LEVEL);
              end else begin
                streak <= streak + 1'b1;
              end
            end else begin
              MISS       <= 1'b1;
              LIVES_LEFT <= LIVES_LEFT - 1'b1;
              streak     <= '0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            state <= (LIVES_LEFT == '0) ? OVER : RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    LEDS = '0;
    case (state)
      RUN:     LEDS = sweep_leds;
      HOLD:    LEDS = {WIDTH{hit_shown}};
      default: LEDS = '0;
    endcase
  end

  assign GAME_OVER = (state == OVER);

endmodule

// File: tb/tb_precision_game_core.sv
// Bench for precision_game_core: directed scenarios plus random play against a behavioural model.
module tb_precision_game_core;

  localparam int W = 8, BD = 8, LV = 4, HPL = 2, LF = 2, HC = 4, SCW = 8;

  logic       CLK = 1'b0;
  logic       RST, START, BTN, MODE;
  logic [7:0] SWITCHES;
  logic [7:0] LEDS;
  logic [7:0] SCORE;
  logic [1:0] LEVEL;
  logic [1:0] LIVES_LEFT;
  logic       HIT, MISS, GAME_OVER;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  precision_game_core #(
    .WIDTH(W), .BASE_DIV(BD), .LEVELS(LV), .HITS_PER_LEVEL(HPL),
    .LIVES(LF), .SCORE_W(SCW), .HOLD_CYC(HC)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .BTN(BTN), .MODE(MODE),
    .SWITCHES(SWITCHES), .LEDS(LEDS), .SCORE(SCORE), .LEVEL(LEVEL),
    .LIVES_LEFT(LIVES_LEFT), .HIT(HIT), .MISS(MISS), .GAME_OVER(GAME_OVER)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase plus elapsed sweep steps; position derived arithmetically.
  int m_phase = 0;  // 0 idle, 1 run, 2 hold, 3 over
  int m_score = 0, m_level = 0, m_lives = LF, m_streak = 0;
  int m_mode = 0, m_steps = 0, m_cyc = 0, m_hold = 0;
  int m_shown = 0, m_hit = 0, m_miss = 0;
  logic [2:0] hs = '0, hb = '0;

  function automatic int pos_of(input int steps, input int pp);
    int p;
    if (pp == 0) return steps % W;
    p = steps % (2 * W - 2);
    return (p < W) ? p : 2 * W - 2 - p;
  endfunction

  task automatic model_step();
    logic se, be;
    int   pos;
    if (RST) begin
      m_phase = 0; m_score = 0; m_level = 0; m_lives = LF; m_streak = 0;
      m_steps = 0; m_cyc = 0; m_hold = 0; m_shown = 0; m_hit = 0; m_miss = 0;
      hs = '0; hb = '0;
      return;
    end
    se = hs[1] & ~hs[2];
    be = hb[1] & ~hb[2];
    hs = {hs[1:0], START};
    hb = {hb[1:0], BTN};
    m_hit = 0; m_miss = 0;
    case (m_phase)
      0, 3: if (se) begin
        m_phase = 1; m_score = 0; m_level = 0; m_lives = LF; m_streak = 0;
        m_steps = 0; m_cyc = 0; m_mode = int'(MODE);
      end
      1: if (be) begin
        pos = pos_of(m_steps, m_mode);
        if (SWITCHES[pos]) begin
          m_hit = 1;
          m_score = (m_score == 255) ? 255 : m_score + 1;
          m_streak++;
          if (m_streak == HPL) begin
            m_streak = 0;
            if (m_level < LV - 1) m_level++;
          end
        end else begin
          m_miss = 1; m_lives--; m_streak = 0;
        end
        m_shown = m_hit; m_phase = 2; m_hold = HC;
      end else begin
        m_cyc++;
        if (m_cyc == (BD >> m_level)) begin
          m_cyc = 0; m_steps++;
        end
      end
      2: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_lives == 0) m_phase = 3;
          else begin m_phase = 1; m_steps = 0; m_cyc = 0; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    int exp_leds;
    case (m_phase)
      1:       exp_leds = 1 << pos_of(m_steps, m_mode);
      2:       exp_leds = m_shown ? 255 : 0;
      default: exp_leds = 0;
    endcase
    check("model_leds", int'(LEDS), exp_leds);
    check("model_score", int'(SCORE), m_score);
    check("model_level", int'(LEVEL), m_level);
    check("model_lives", int'(LIVES_LEFT), m_lives);
    check("model_hit", int'(HIT), m_hit);
    check("model_miss", int'(MISS), m_miss);
    check("model_game_over", int'(GAME_OVER), (m_phase == 3) ? 1 : 0);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      compare();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_leds(input logic [7:0] v, input int budget, input string name);
    int i = 0;
    while (LEDS !== v && i < budget) begin
      tick(1);
      i++;
    end
    check(name, int'(LEDS), int'(v));
  endtask

  task automatic wait_run(input int budget);
    int i = 0;
    while (!$onehot(LEDS) && i < budget) begin
      tick(1);
      i++;
    end
    check("wait_run_onehot", int'($onehot(LEDS)), 1);
  endtask

  task automatic press();
    BTN = 1'b1;
    tick(3);
    BTN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; BTN = 1'b0; MODE = 1'b0; SWITCHES = 8'h00;
    tick(3);
    RST = 1'b0;
    check("rst_leds", int'(LEDS), 0);
    check("rst_lives", int'(LIVES_LEFT), 2);
    check("rst_score", int'(SCORE), 0);
    check("rst_game_over", int'(GAME_OVER), 0);
    tick(2);

    // Wrap sweep, start latency and step period 8
    START = 1'b1;
    tick(3);
    START = 1'b0;
    check("start_led0", int'(LEDS), 8'h01);
    check("start_lives", int'(LIVES_LEFT), 2);
    tick(8);
    check("step_led1", int'(LEDS), 8'h02);

    // Single hit on position 3
    SWITCHES = 8'h08;
    wait_leds(8'h08, 64, "reach_led3");
    press();
    check("hit_pulse", int'(HIT), 1);
    check("hit_score", int'(SCORE), 1);
    check("hit_leds", int'(LEDS), 8'hFF);
    tick(1);
    check("hit_pulse_end", int'(HIT), 0);
    check("hold_leds2", int'(LEDS), 8'hFF);
    tick(2);
    check("hold_leds4", int'(LEDS), 8'hFF);
    tick(1);
    check("hold_exit_led0", int'(LEDS), 8'h01);

    // Level advance and period shrink
    wait_leds(8'h08, 64, "reach_led3_b");
    press();
    check("level1", int'(LEVEL), 1);
    check("score2", int'(SCORE), 2);
    wait_leds(8'h01, 16, "after_hold_l1");
    tick(4);
    check("period4", int'(LEDS), 8'h02);

    SWITCHES = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wait_run(32);
      press();
      check("hit_ff", int'(HIT), 1);
    end
    check("level3", int'(LEVEL), 3);
    check("score6", int'(SCORE), 6);
    wait_leds(8'h01, 16, "after_hold_l3");
    tick(1);
    check("period1", int'(LEDS), 8'h02);
    for (int i = 0; i < 2; i++) begin
      wait_run(32);
      press();
    end
    check("level_sat", int'(LEVEL), 3);
    check("score8", int'(SCORE), 8);

    // Misses until game over
    SWITCHES = 8'h00;
    wait_run(32);
    press();
    check("miss1_pulse", int'(MISS), 1);
    check("miss1_lives", int'(LIVES_LEFT), 1);
    check("miss1_leds", int'(LEDS), 0);
    wait_run(32);
    press();
    check("miss2_pulse", int'(MISS), 1);
    check("miss2_lives", int'(LIVES_LEFT), 0);
    tick(4);
    check("over_flag", int'(GAME_OVER), 1);
    check("over_leds", int'(LEDS), 0);
    check("over_score", int'(SCORE), 8);
    check("over_level", int'(LEVEL), 3);

    // Restart in ping-pong mode
    MODE = 1'b1;
    START = 1'b1;
    tick(3);
    START = 1'b0;
    check("restart_score", int'(SCORE), 0);
    check("restart_lives", int'(LIVES_LEFT), 2);
    check("restart_over", int'(GAME_OVER), 0);
    check("restart_led0", int'(LEDS), 8'h01);
    wait_leds(8'h80, 100, "pp_reach_top");
    tick(8);
    check("pp_turn_top", int'(LEDS), 8'h40);
    wait_leds(8'h01, 100, "pp_reach_bottom");
    tick(8);
    check("pp_turn_bottom", int'(LEDS), 8'h02);

    // Press evaluated on the terminal-count edge of position 7
    SWITCHES = 8'h80;
    wait_leds(8'h80, 100, "pp_reach_top_b");
    tick(5);
    press();
    check("pre_advance_hit", int'(HIT), 1);
    check("pre_advance_score", int'(SCORE), 1);

    // START and BTN together from IDLE
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(2);
    MODE = 1'b0;
    START = 1'b1;
    BTN = 1'b1;
    tick(3);
    check("dual_led0", int'(LEDS), 8'h01);
    check("dual_no_hit", int'(HIT), 0);
    check("dual_no_miss", int'(MISS), 0);
    START = 1'b0;
    BTN = 1'b0;
    tick(1);
    check("dual_still_run", int'(LEDS), 8'h01);
    check("dual_no_hit2", int'(HIT | MISS), 0);

    // Reset in the middle of HOLD
    SWITCHES = 8'hFF;
    press();
    check("pre_rst_hold", int'(LEDS), 8'hFF);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    check("midrst_leds", int'(LEDS), 0);
    check("midrst_score", int'(SCORE), 0);
    check("midrst_level", int'(LEVEL), 0);
    check("midrst_lives", int'(LIVES_LEFT), 2);
    check("midrst_flags", int'({HIT, MISS, GAME_OVER}), 0);

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) BTN = ~BTN;
      if ($urandom_range(0, 29) == 0) START = ~START;
      if ($urandom_range(0, 15) == 0) MODE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) SWITCHES = 8'($urandom);
      RST = ($urandom_range(0, 799) == 0);
      tick(1);
    end
    RST = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
